eth_fcs_append: RTL
===================

ETH_FCS_APPEND -- requirements
Module: eth_fcs_append

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60, the minimum payload length in bytes before the FCS; 0 disables padding.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port inData  input  8  payload byte.
REQ-005 SHALL have port inValid  input  1  inData/inLast valid.
REQ-006 SHALL have port inLast  input  1  final payload byte of the frame.
REQ-007 SHALL have port inReady  output  1  byte accepted when inValid && inReady.
REQ-008 SHALL have port outData  output  8  frame byte: payload, pad or FCS.
REQ-009 SHALL have port outValid  output  1  outData/outLast valid.
REQ-010 SHALL have port outLast  output  1  final FCS byte.
REQ-011 SHALL have port outReady  input  1  downstream accepts when outValid && outReady.

Function
REQ-012 SHALL run the CRC-32 Ethernet code (poly 0xEDB88320, reflected, byte-wise), with init 0xFFFFFFFF and output XOR 0xFFFFFFFF.
REQ-013 SHALL use three states: DATA (pass payload), PAD (emit 0x00 bytes), FCS (emit 4 FCS bytes).
REQ-014 SHALL drive inReady = (state==DATA) && (!outValid || outReady); inReady SHALL be 0 in PAD and FCS.
REQ-015 SHALL register outputs; an accepted input byte appears on outData one cycle later.
REQ-016 SHALL hold outData, outValid and outLast stable while outValid && !outReady.
REQ-017 SHALL advance the CRC register with every payload byte and every pad byte when that byte is loaded into the output register.
REQ-018 SHALL keep a byte counter that saturates at MIN_LEN, is incremented per payload or pad byte, and is cleared at frame end.
REQ-019 On acceptance of an inLast byte, SHALL go to PAD if (count+1) < MIN_LEN, else to FCS.
REQ-020 In PAD, SHALL emit 0x00 bytes until count reaches MIN_LEN, then go to FCS.
REQ-021 In FCS, SHALL emit the bytes of ~crc from bits [7:0] up to bits [31:24], and assert outLast only on the fourth byte.
REQ-022 When the fourth FCS byte is loaded, SHALL go to DATA, reload the CRC with 0xFFFFFFFF and clear count, so the next frame can start on the following cycle.
REQ-023 SHALL never produce a zero-payload frame; a frame always contains at least the byte that carries inLast.
REQ-024 Payloads longer than MIN_LEN SHALL pass without truncation; the saturated count SHALL not wrap.

Reset
REQ-025 While rst=1, SHALL hold state=DATA, crc=0xFFFFFFFF, count=0, outValid=0, outLast=0, outData=0x00, inReady=0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no FCS emitted; after reset deasserts, the first accepted byte starts a new frame.

Structure
REQ-027 SHALL take the state enum, CRC_INIT=32'hFFFFFFFF, CRC_XOROUT=32'hFFFFFFFF and ETH_MIN_LEN=60 from a shared package.
REQ-028 SHALL instantiate the team's combinational byte-wise CRC-32 step module (crcIn, data, crcOut) once as its only sub-module, and SHALL not duplicate its equations.
REQ-029 SHALL contain the CRC register, the counter, the FCS byte index (2 bits), the FSM and the output register.

Verification
REQ-030 MIN_LEN=0, payload ASCII "123456789", outReady=1 -> the 9 payload bytes, then 0x26 0x39 0xF4 0xCB, with outLast on 0xCB.
REQ-031 Default MIN_LEN, single byte 0x00 with inLast -> 64 output beats (1 data, 59 pad 0x00, 4 FCS), FCS equal to the software model.
REQ-032 Default MIN_LEN, 60-byte payload -> no pad bytes, 64 beats; a 61-byte payload -> 65 beats.
REQ-033 Random outReady (50%), 100-byte frames -> output stable under stall, byte stream identical to the model, no loss or duplication.
REQ-034 Two identical frames back-to-back with inValid held high -> identical FCS on both (CRC reinitialised), with no idle cycle required between frames.
REQ-035 rst pulsed at payload byte 10 -> outValid=0 in the same cycle, no FCS emitted; the next frame's FCS matches the model.

Source files
------------

// File: rtl/eth_fcs_append_pkg.sv
// Shared constants for the Ethernet FCS appender: FSM encoding, CRC-32 parameters
// and the helper that selects one FCS byte from the running CRC.
package eth_fcs_append_pkg;

    typedef logic [1:0] fcs_state_t;

    localparam fcs_state_t ST_DATA = 2'd0;
    localparam fcs_state_t ST_PAD  = 2'd1;
    localparam fcs_state_t ST_FCS  = 2'd2;

    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;

    localparam int ETH_MIN_LEN = 60;

    // FCS goes out least-significant byte first.
    function automatic logic [7:0] fcsByte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] fcs;
        fcs = crc ^ CRC_XOROUT;
        case (idx)
            2'd0:    fcsByte = fcs[7:0];
            2'd1:    fcsByte = fcs[15:8];
            2'd2:    fcsByte = fcs[23:16];
            2'd3:    fcsByte = fcs[31:24];
            default: fcsByte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/eth_fcs_append_crc_step.sv
// Combinational byte-wise CRC-32 step (reflected, poly 0xEDB88320).
module eth_fcs_append_crc_step
    import eth_fcs_append_pkg::*;
(
    input  logic [31:0] crcIn,
    input  logic [7:0]  data,
    output logic [31:0] crcOut
);

    // Eight shift/XOR rounds, one per data bit, LSB first.
    always_comb begin
        crcOut = crcIn ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (crcOut[0]) begin
                crcOut = (crcOut >> 1) ^ CRC_POLY;
            end else begin
                crcOut = crcOut >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_fcs_append.sv
// Streams payload bytes through, pads short frames with zeros up to MIN_LEN and
// appends the 4-byte Ethernet FCS, with a registered ready/valid output stage.
module eth_fcs_append
    import eth_fcs_append_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inData,
    input  logic       inValid,
    input  logic       inLast,
    output logic       inReady,
    output logic [7:0] outData,
    output logic       outValid,
    output logic       outLast,
    input  logic       outReady
);

    // One spare bit on countPlus_s lets the compare against MIN_LEN never wrap.
    localparam int CNT_W = (MIN_LEN < 1) ? 1 : $clog2(MIN_LEN + 1);
    localparam logic [CNT_W:0] MIN_LEN_C = MIN_LEN[CNT_W:0];

    fcs_state_t       state_r;
    logic [31:0]      crc_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       fcsIdx_r;
    logic [7:0]       outData_r;
    logic             outValid_r;
    logic             outLast_r;

    logic [31:0]      crcNext_s;
    logic [7:0]       crcByte_s;
    logic [CNT_W:0]   countPlus_s;
    logic [CNT_W-1:0] countSat_s;
    logic             needPad_s;
    logic             outFree_s;
    logic             accept_s;

    eth_fcs_append_crc_step uCrcStep (
        .crcIn  (crc_r),
        .data   (crcByte_s),
        .crcOut (crcNext_s)
    );

    // Byte fed to the CRC, counter arithmetic and handshake qualifiers.
    always_comb begin
        if (state_r == ST_PAD) begin
            crcByte_s = 8'h00;
        end else begin
            crcByte_s = inData;
        end
        countPlus_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
        if (countPlus_s >= MIN_LEN_C) begin
            countSat_s = MIN_LEN_C[CNT_W-1:0];
        end else begin
            countSat_s = countPlus_s[CNT_W-1:0];
        end
        needPad_s = (countPlus_s < MIN_LEN_C);
        outFree_s = !outValid_r || outReady;
        inReady   = !rst && (state_r == ST_DATA) && outFree_s;
        accept_s  = inValid && inReady;
    end

    // FSM, CRC register, byte counter, FCS index and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_DATA;
            crc_r      <= CRC_INIT;
            count_r    <= {CNT_W{1'b0}};
            fcsIdx_r   <= 2'd0;
            outData_r  <= 8'h00;
            outValid_r <= 1'b0;
            outLast_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_DATA: begin
                    if (accept_s) begin
                        outData_r  <= inData;
                        outValid_r <= 1'b1;
                        outLast_r  <= 1'b0;
                        crc_r      <= crcNext_s;
                        count_r    <= countSat_s;
                        if (inLast) begin
                            state_r <= needPad_s ? ST_PAD : ST_FCS;
                        end
                    end else if (outFree_s) begin
                        outValid_r <= 1'b0;
                        outLast_r  <= 1'b0;
                    end
                end
                ST_PAD: begin
                    if (outFree_s) begin
                        outData_r  <= 8'h00;
                        outValid_r <= 1'b1;
                        outLast_r  <= 1'b0;
                        crc_r      <= crcNext_s;
                        count_r    <= countSat_s;
                        if (!needPad_s) begin
                            state_r <= ST_FCS;
                        end
                    end
                end
                ST_FCS: begin
                    if (outFree_s) begin
                        outData_r  <= fcsByte(crc_r, fcsIdx_r);
                        outValid_r <= 1'b1;
                        outLast_r  <= (fcsIdx_r == 2'd3);
                        fcsIdx_r   <= fcsIdx_r + 2'd1;
                        if (fcsIdx_r == 2'd3) begin
                            state_r <= ST_DATA;
                            crc_r   <= CRC_INIT;
                            count_r <= {CNT_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r    <= ST_DATA;
                    crc_r      <= CRC_INIT;
                    count_r    <= {CNT_W{1'b0}};
                    fcsIdx_r   <= 2'd0;
                    outValid_r <= 1'b0;
                    outLast_r  <= 1'b0;
                end
            endcase
        end
    end

    assign outData  = outData_r;
    assign outValid = outValid_r;
    assign outLast  = outLast_r;

endmodule
